clk_enable_gen: RTL and testbench
=================================

Name: clk_enable_gen

Overview:
- Parametrised successor to the fixed two-output system PLL wrapper: derives NUM_CH independent fractional-rate clock enables from the single 50 MHz reference clock using per-channel phase accumulators (NCOs).
- Rates are runtime-reprogrammable, so core/peripheral timing (4.000000 MHz, 4.194528 MHz, others) can change without rebuilding a PLL.
- Sits beside the PLL. Consumers run on refclk and qualify logic with clk_en[i].

Parameters:
- NUM_CH, 2, number of enable channels (1..8).
- ACC_W, 32, phase accumulator width in bits (16..48).
- INIT_INC, {32'd360307212, 32'd343597384}, packed NUM_CH*ACC_W reset increments. Channel 0 is in bits [ACC_W-1:0]. Defaults give 4.000000 MHz (ch0) and 4.194528 MHz (ch1) at 50 MHz.
- LOCK_CYCLES, 16, cycles after reset or reconfiguration before locked asserts (≥1).

Ports:
- refclk  in  1  reference clock, sole clock domain.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  reconfiguration may be accepted.
- cfg_chan  in  3  target channel index.
- cfg_inc  in  ACC_W  new phase increment.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_chan ≥ NUM_CH.
- phase_sync  in  1  clears all accumulators together (phase alignment).
- clk_en  out  NUM_CH  one-cycle enable pulses, one bit per channel.
- locked  out  1  all channels running at programmed rates.

Behaviour:
- Reset is synchronous and active-high. All registers are sampled on the rising edge of refclk while rst=1.
- Reset values: acc[i]=0, inc[i]=INIT_INC slice, clk_en=0, locked=0, cfg_err=0, lock counter=0.
- cfg_ready=0 while rst=1 or the lock counter is running. Otherwise cfg_ready=1, i.e. cfg_ready equals locked outside reset.
- Per channel, every cycle: sum = {1'b0,acc[i]} + inc[i], computed ACC_W+1 bits wide. acc[i] <= sum[ACC_W-1:0] (natural wrap). clk_en[i] <= sum[ACC_W].
- Latency: clk_en is registered, so it asserts in the cycle after the carry is generated.
- Average rate = f_refclk*inc/2^ACC_W. There are never two pulses in consecutive cycles unless inc ≥ 2^(ACC_W-1).
- inc=0: channel is silent and acc holds its value. inc=2^ACC_W-1: the channel pulses on all but one cycle in each 2^ACC_W-cycle period.
- First pulse after reset release: clk_en[i] asserts in cycle ceil(2^ACC_W/inc[i]), counting the first cycle with rst=0 as cycle 1.
- Lock counter: increments each cycle from 0 while < LOCK_CYCLES. locked=1 when the count equals LOCK_CYCLES, so locked rises LOCK_CYCLES cycles after reset release.
- Config handshake: a write is accepted when cfg_valid && cfg_ready. The next edge does all of the following:
  - inc[cfg_chan] <= cfg_inc and acc[cfg_chan] <= 0.
  - Lock counter <= 0; locked falls in the same cycle cfg_ready falls.
  - Channel cfg_chan outputs no clk_en pulse that cycle.
  - Other channels continue undisturbed.
- cfg_valid while cfg_ready=0 is ignored; no queueing. The requester must hold cfg_valid until it is accepted.
- cfg_chan ≥ NUM_CH: the write is accepted but changes no state, including the lock counter. cfg_err pulses for 1 cycle and locked stays high.
- phase_sync=1: all acc <= 0 and all clk_en <= 0 on the next edge. locked and inc are unaffected.
- phase_sync together with an accepted write: phase_sync clears all accumulators and the write updates inc and restarts lock.
- rst asserted mid-reconfiguration or mid-lock: everything returns to reset values. INIT_INC is restored and any programmed increment is lost.
- Widths: cfg_inc uses the full ACC_W width. The upper unused bits of cfg_chan are decoded; any value ≥ NUM_CH is an error.

Optional Feature:
- Macro: CLK_ENABLE_GEN_SQUARE_EN.
- Defined: adds output port clk_sq [NUM_CH]. Each bit toggles on every clk_en pulse of its channel, giving a square wave at half the enable rate. Reset value 0. Cleared by phase_sync and by a reconfiguration of that channel. The output is for debug or pin export only, never as a clock.
- Undefined: the clk_sq port and its registers do not exist. All other behaviour is identical.

Test Plan:
- Reset release with defaults, rst low for 50,000 cycles: ch0 gives exactly 4000 pulses; ch1 gives 4194 or 4195 pulses. locked rises in cycle 16. cfg_ready=0 before cycle 16.
- Write cfg_chan=0, cfg_inc=32'h8000_0000 after lock: accepted in one cycle and locked drops. ch0 then pulses every 2nd cycle with its first pulse 2 cycles after acceptance. ch1 cadence is unchanged. locked returns 16 cycles later.
- Write cfg_chan=5, NUM_CH=2: cfg_err pulses for 1 cycle. No inc, acc or locked change. cfg_valid held during lock shows no acceptance until cfg_ready=1.
- Program ch1 to cfg_inc=0: no pulses on ch1 for 10,000 cycles. Then pulse phase_sync with both channels at 32'h4000_0000: both channels pulse in the same cycles, every 4 cycles.
- Assert rst for 1 cycle mid-lock after reprogramming ch0: inc reverts to 343597384. The lock sequence restarts and the first ch0 pulse lands at cycle 13 after release.
- With CLK_ENABLE_GEN_SQUARE_EN and ch0 at 32'h8000_0000: clk_sq[0] period is 4 cycles with 50% duty. clk_sq[0]=0 after phase_sync.

Source files
------------

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CH fractional-rate clock enables derived from refclk with
// per-channel phase accumulators (NCOs). Increments are reprogrammable at runtime
// through a valid/ready write port. The lock counter restarts on every real write.
//
// Optional build macro CLK_ENABLE_GEN_SQUARE_EN adds clk_sq. It holds one
// divide-by-two square wave per channel that toggles on each clk_en pulse. It is
// meant for debug or pin export and must never be used as a clock.
module clk_enable_gen #(
    parameter int unsigned                 NUM_CH      = 2,
    parameter int unsigned                 ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0]     INIT_INC    = {32'd360307212, 32'd343597384},
    parameter int unsigned                 LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_chan,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_err,
    input  logic              phase_sync,
    output logic [NUM_CH-1:0] clk_en,
    output logic              locked
`ifdef CLK_ENABLE_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] clk_sq
`endif
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    // Per-channel NCO state.
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [ACC_W:0]    sum   [NUM_CH];
    logic [NUM_CH-1:0] clk_en_q;
    logic [NUM_CH-1:0] clk_en_d;

    // Configuration and lock state.
    logic              cfg_err_q;
    logic              cfg_err_d;
    logic [CNT_W-1:0]  lock_cnt_q;
    logic [CNT_W-1:0]  lock_cnt_d;

    logic              cfg_accept;
    logic              chan_ok;
    logic [NUM_CH-1:0] chan_sel;

`ifdef CLK_ENABLE_GEN_SQUARE_EN
    logic [NUM_CH-1:0] clk_sq_q;
    logic [NUM_CH-1:0] clk_sq_d;
`endif

    // Decode the write handshake. Out-of-range channels are accepted but select nothing.
    always_comb begin
        locked     = (lock_cnt_q == LOCK_MAX);
        cfg_ready  = locked && !rst;
        cfg_accept = cfg_valid && cfg_ready;
        chan_ok    = (32'(cfg_chan) < NUM_CH);
        chan_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chan_sel[i] = cfg_accept && chan_ok && (int'(cfg_chan) == i);
        end
    end

    // The NCO adds the increment each cycle. The carry out of the accumulator is the enable.
    always_comb begin
        clk_en_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i] = sum[i][ACC_W-1:0];
            inc_d[i] = inc_q[i];
            clk_en_d[i] = sum[i][ACC_W];
            // phase_sync clears every accumulator. A write also clears its own channel.
            if (phase_sync || chan_sel[i]) begin
                acc_d[i]    = '0;
                clk_en_d[i] = 1'b0;
            end
            if (chan_sel[i]) begin
                inc_d[i] = cfg_inc;
            end
        end
    end

    // The lock counter restarts on a real write and saturates at LOCK_CYCLES.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (cfg_accept && chan_ok) begin
            lock_cnt_d = '0;
        end else if (!locked) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        cfg_err_d = cfg_accept && !chan_ok;
    end

    // Register the NCO state. Reset restores the build-time increments.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
            end
            clk_en_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
            clk_en_q <= clk_en_d;
        end
    end

    // Register the lock counter and the error pulse.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef CLK_ENABLE_GEN_SQUARE_EN
    // The square output toggles with each new enable pulse and clears with its accumulator.
    always_comb begin
        clk_sq_d = clk_sq_q ^ clk_en_d;
        for (int i = 0; i < NUM_CH; i++) begin
            if (phase_sync || chan_sel[i]) begin
                clk_sq_d[i] = 1'b0;
            end
        end
    end

    // Register the square wave outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            clk_sq_q <= '0;
        end else begin
            clk_sq_q <= clk_sq_d;
        end
    end

    assign clk_sq = clk_sq_q;
`endif

    assign clk_en  = clk_en_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Testbench for clk_enable_gen. A reference model predicts each enable from the
// integer pulse count floor(k*inc/2^32), where k is the number of cycles since
// that channel's phase was last cleared.
module tb_clk_enable_gen;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned LOCK_CYCLES = 16;
    localparam longint unsigned INC0 = 64'd343597384;
    localparam longint unsigned INC1 = 64'd360307212;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [2:0]  cfg_chan;
    logic [31:0] cfg_inc;
    logic        phase_sync;
    wire         cfg_ready;
    wire         cfg_err;
    wire         locked;
    wire  [1:0]  clk_en;
`ifdef CLK_ENABLE_GEN_SQUARE_EN
    wire  [1:0]  clk_sq;
`endif

    always #10 refclk = ~refclk;

    clk_enable_gen dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_inc    (cfg_inc),
        .cfg_err    (cfg_err),
        .phase_sync (phase_sync),
        .clk_en     (clk_en),
        .locked     (locked)
`ifdef CLK_ENABLE_GEN_SQUARE_EN
        ,
        .clk_sq     (clk_sq)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    longint unsigned m_inc [NUM_CH];
    longint unsigned m_k   [NUM_CH];
    int              m_lock;
    logic [1:0]      m_en;
    logic [1:0]      m_sq;
    logic            m_err;
    int              pulse_cnt [NUM_CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inc[0] = INC0;
        m_inc[1] = INC1;
        m_k[0]   = 0;
        m_k[1]   = 0;
        m_lock   = 0;
        m_en     = '0;
        m_sq     = '0;
        m_err    = 1'b0;
    endtask

    // Advance one clock cycle. The model is updated with the inputs that the edge samples.
    task automatic tick();
        logic wr_acc;
        logic ch_ok;
        #1;
        check("cfg_ready", cfg_ready, (m_lock == LOCK_CYCLES) && !rst);
        wr_acc = cfg_valid && (m_lock == LOCK_CYCLES) && !rst;
        ch_ok  = (cfg_chan < NUM_CH);
        @(posedge refclk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_acc && ch_ok && (cfg_chan == c)) begin
                    m_inc[c] = cfg_inc;
                    m_k[c]   = 0;
                    m_en[c]  = 1'b0;
                    m_sq[c]  = 1'b0;
                end else if (phase_sync) begin
                    m_k[c]  = 0;
                    m_en[c] = 1'b0;
                    m_sq[c] = 1'b0;
                end else begin
                    m_k[c]++;
                    m_en[c] = ((m_k[c] * m_inc[c]) >> 32) != (((m_k[c] - 1) * m_inc[c]) >> 32);
                    if (m_en[c]) m_sq[c] = ~m_sq[c];
                end
            end
            m_err = wr_acc && !ch_ok;
            if (wr_acc && ch_ok) m_lock = 0;
            else if (m_lock < LOCK_CYCLES) m_lock++;
        end
        for (int c = 0; c < NUM_CH; c++) if (clk_en[c] === 1'b1) pulse_cnt[c]++;
        check("clk_en", clk_en, m_en);
        check("locked", locked, m_lock == LOCK_CYCLES);
        check("cfg_err", cfg_err, m_err);
`ifdef CLK_ENABLE_GEN_SQUARE_EN
        check("clk_sq", clk_sq, m_sq);
`endif
    endtask

    // Hold a write request until the model says it is accepted. The wait is bounded.
    task automatic do_write(input logic [2:0] ch, input logic [31:0] v);
        bit done = 0;
        int waited = 0;
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_inc   = v;
        while (!done && waited < 64) begin
            done = (m_lock == LOCK_CYCLES);
            tick();
            waited++;
        end
        cfg_valid = 1'b0;
        if (!done) check("write_timeout", 1, 0);
    endtask

    function automatic logic [31:0] pick_inc();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'h4000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(1000, 1));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int first;
        bit pend;
        model_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0; phase_sync = 1'b0;
        repeat (3) tick();

        // Defaults over 50,000 cycles from reset release.
        rst = 1'b0;
        pulse_cnt[0] = 0; pulse_cnt[1] = 0;
        for (int n = 1; n <= 50000; n++) begin
            tick();
            if (n == 15) check("locked_c15", locked, 0);
            if (n == 16) check("locked_c16", locked, 1);
        end
        check("ch0_pulses_50k", pulse_cnt[0], 4000);
        check("ch1_pulses_50k_ok", (pulse_cnt[1] == 4194) || (pulse_cnt[1] == 4195), 1);

        // A half-rate write to ch0. The out-of-range write that follows is held through lock.
        do_write(3'd0, 32'h8000_0000);
        do_write(3'd5, 32'h1234_5678);
        repeat (20) tick();

        // A silent ch1.
        do_write(3'd1, 32'h0);
        pulse_cnt[1] = 0;
        repeat (10000) tick();
        check("ch1_silent_10k", pulse_cnt[1], 0);

        // Align both channels at quarter rate.
        do_write(3'd0, 32'h4000_0000);
        do_write(3'd1, 32'h4000_0000);
        repeat (20) tick();
        phase_sync = 1'b1; tick(); phase_sync = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            check("sync_equal", clk_en[0], clk_en[1]);
        end

        // Reset in the middle of lock reverts to INIT_INC. The first ch0 pulse comes at cycle 13.
        do_write(3'd0, 32'h8000_0000);
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (first == 0 && clk_en[0] === 1'b1) first = n;
        end
        check("first_pulse_after_rst", first, 13);

        // Randomized traffic.
        pend = 0;
        for (int n = 0; n < 8000; n++) begin
            rst        = ($urandom_range(499) == 0);
            phase_sync = ($urandom_range(49) == 0);
            if (!pend && $urandom_range(19) == 0) begin
                pend      = 1;
                cfg_valid = 1'b1;
                cfg_chan  = 3'($urandom_range(7));
                cfg_inc   = pick_inc();
            end
            if (pend && (m_lock == LOCK_CYCLES) && !rst) pend = 0;
            tick();
            if (!pend) cfg_valid = 1'b0;
        end
        rst = 1'b0; phase_sync = 1'b0; cfg_valid = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
